// File: rtl/cpu_defs.sv
// Shared definitions for the multicycle controller: states, opcode fields, select codes.
package cpu_defs;

  localparam int unsigned SIZE = 16;

  typedef enum logic [3:0] {
    S_FETCH,
    S_LATCH,
    S_DECODE,
    S_ALU,
    S_LOAD,
    S_LOAD_WB,
    S_STORE,
    S_BRANCH,
    S_JUMP,
    S_JAL,
    S_NOP
  } state_e;

  // Primary opcodes ([15:12]) that are not plain immediate ALU ops
  localparam logic [3:0] OP_RTYPE   = 4'b0000;
  localparam logic [3:0] OP_SPECIAL = 4'b0100;
  localparam logic [3:0] OP_BCOND   = 4'b1100;
  localparam logic [3:0] OP_LUI     = 4'b1111;

  // ALU ext codes; immediate forms reuse the same value as their opcode
  localparam logic [3:0] EXT_AND = 4'b0001;
  localparam logic [3:0] EXT_OR  = 4'b0010;
  localparam logic [3:0] EXT_XOR = 4'b0011;
  localparam logic [3:0] EXT_ADD = 4'b0101;
  localparam logic [3:0] EXT_SUB = 4'b1001;
  localparam logic [3:0] EXT_CMP = 4'b1011;
  localparam logic [3:0] EXT_MOV = 4'b1101;

  // Ext codes under OP_SPECIAL
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  // Condition codes ([11:8])
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_FS = 4'b0100;
  localparam logic [3:0] COND_FC = 4'b0101;
  localparam logic [3:0] COND_GT = 4'b0110;
  localparam logic [3:0] COND_LE = 4'b0111;
  localparam logic [3:0] COND_LO = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1100;
  localparam logic [3:0] COND_UC = 4'b1110;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_CMP = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;

  localparam logic [1:0] PCM_INC  = 2'd0;
  localparam logic [1:0] PCM_RTGT = 2'd1;
  localparam logic [1:0] PCM_ALU  = 2'd2;

  localparam logic [1:0] A2M_RF   = 2'd0;
  localparam logic [1:0] A2M_NIB  = 2'd1;
  localparam logic [1:0] A2M_SEXT = 2'd2;

  localparam logic [1:0] RWM_MEM  = 2'd0;
  localparam logic [1:0] RWM_LINK = 2'd1;
  localparam logic [1:0] RWM_ALU  = 2'd2;
  localparam logic [1:0] RWM_LUI  = 2'd3;

  // Control word presented to the datapath
  typedef struct packed {
    logic       mem_w2_en;
    logic       rf_en;
    logic       psr_en;
    logic       pc_en;
    logic       instr_en;
    logic       movm;
    logic       a1m;
    logic [1:0] pcm;
    logic [1:0] a2m;
    logic [1:0] rwm;
    logic [3:0] alu_op;
  } ctrl_t;

  function automatic logic is_alu_ext(input logic [3:0] e);
    return e inside {EXT_ADD, EXT_SUB, EXT_CMP, EXT_AND, EXT_OR, EXT_XOR};
  endfunction

  function automatic logic [3:0] alu_op_of(input logic [3:0] e);
    logic [3:0] op;
    op = ALU_ADD;
    case (e)
      EXT_SUB: op = ALU_SUB;
      EXT_CMP: op = ALU_CMP;
      EXT_AND: op = ALU_AND;
      EXT_OR:  op = ALU_OR;
      EXT_XOR: op = ALU_XOR;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Execute state selected by the decode step
  function automatic state_e exec_state(input logic [3:0] opcode, input logic [3:0] ext);
    state_e s;
    s = S_NOP;
    case (opcode)
      OP_RTYPE:   s = (is_alu_ext(ext) || ext == EXT_MOV) ? S_ALU : S_NOP;
      OP_LUI:     s = S_ALU;
      OP_BCOND:   s = S_BRANCH;
      OP_SPECIAL: begin
        case (ext)
          EXT_LOAD:  s = S_LOAD;
          EXT_STOR:  s = S_STORE;
          EXT_JAL:   s = S_JAL;
          EXT_JCOND: s = S_JUMP;
          default:   s = S_NOP;
        endcase
      end
      default:    s = (is_alu_ext(opcode) || opcode == EXT_MOV) ? S_ALU : S_NOP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/cond_check.sv
// Evaluates a branch/jump condition code against the PSR flags.
module cond_check
  import cpu_defs::*;
(
  input  logic [3:0] cond,
  input  logic [1:0] flags1,
  input  logic [2:0] flags2,
  output logic       take_c
);

  logic c_flag, l_flag, f_flag, z_flag, n_flag;

  assign c_flag = flags1[1];
  assign l_flag = flags1[0];
  assign f_flag = flags2[2];
  assign z_flag = flags2[1];
  assign n_flag = flags2[0];

  // Condition truth table; unlisted codes are never taken
  always_comb begin
    take_c = 1'b0;
    case (cond)
      COND_EQ: take_c = z_flag;
      COND_NE: take_c = ~z_flag;
      COND_CS: take_c = c_flag;
      COND_CC: take_c = ~c_flag;
      COND_FS: take_c = f_flag;
      COND_FC: take_c = ~f_flag;
      COND_GT: take_c = n_flag;
      COND_LE: take_c = ~n_flag;
      COND_LO: take_c = ~l_flag & ~z_flag;
      COND_LT: take_c = ~n_flag & ~z_flag;
      COND_UC: take_c = 1'b1;
      default: take_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multicycle fetch/decode/execute controller driving datapath enables and selects.
module control_fsm
  import cpu_defs::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [SIZE-1:0] instr,
  input  logic [1:0]      flags1out,
  input  logic [2:0]      flags2out,
  output logic            MemW1en,
  output logic            MemW2en,
  output logic            RFen,
  output logic            PSRen,
  output logic            PCen,
  output logic            INSTRen,
  output logic            Movm,
  output logic            A1m,
  output logic [1:0]      PCm,
  output logic [1:0]      A2m,
  output logic [1:0]      RWm,
  output logic [3:0]      aluOp
);

  state_e     state_q, state_d;
  ctrl_t      ctrl_q, ctrl_d, ctrl_out_c;
  logic [3:0] opcode, cond, ext, alu_sel;
  logic       take_c;
  logic       unused_instr_bits;

  assign opcode            = instr[15:12];
  assign cond              = instr[11:8];
  assign ext               = instr[7:4];
  assign unused_instr_bits = ^instr[3:0];

  cond_check u_cond_check (
    .cond   (cond),
    .flags1 (flags1out),
    .flags2 (flags2out),
    .take_c (take_c)
  );

  // State and control-word registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Next-state sequencing; every execute state returns to fetch
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_LATCH;
      S_LATCH:  state_d = S_DECODE;
      S_DECODE: state_d = exec_state(opcode, ext);
      S_LOAD:   state_d = S_LOAD_WB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Control word for the state being entered, so outputs come straight from flops
  always_comb begin
    ctrl_d  = '0;
    alu_sel = (opcode == OP_RTYPE) ? ext : opcode;
    case (state_d)
      S_LATCH: ctrl_d.instr_en = 1'b1;
      S_ALU: begin
        ctrl_d.pc_en = 1'b1;
        ctrl_d.pcm   = PCM_INC;
        ctrl_d.rf_en = 1'b1;
        if (opcode == OP_LUI) begin
          ctrl_d.rwm = RWM_LUI;
        end else begin
          ctrl_d.rwm = RWM_ALU;
          if (opcode == OP_RTYPE)
            ctrl_d.a2m = A2M_RF;
          else if (alu_sel inside {EXT_AND, EXT_OR, EXT_XOR})
            ctrl_d.a2m = A2M_NIB;
          else
            ctrl_d.a2m = A2M_SEXT;
          if (alu_sel != EXT_MOV) begin
            ctrl_d.movm   = 1'b1;
            ctrl_d.psr_en = 1'b1;
            ctrl_d.alu_op = alu_op_of(alu_sel);
            ctrl_d.rf_en  = (alu_sel != EXT_CMP);
          end
        end
      end
      S_LOAD_WB: begin
        ctrl_d.rwm   = RWM_MEM;
        ctrl_d.rf_en = 1'b1;
        ctrl_d.pcm   = PCM_INC;
        ctrl_d.pc_en = 1'b1;
      end
      S_STORE: begin
        ctrl_d.mem_w2_en = 1'b1;
        ctrl_d.pcm       = PCM_INC;
        ctrl_d.pc_en     = 1'b1;
      end
      S_BRANCH: begin
        ctrl_d.a1m    = 1'b1;
        ctrl_d.a2m    = A2M_SEXT;
        ctrl_d.alu_op = ALU_ADD;
        ctrl_d.pcm    = take_c ? PCM_ALU : PCM_INC;
        ctrl_d.pc_en  = 1'b1;
      end
      S_JUMP: begin
        ctrl_d.pcm   = take_c ? PCM_RTGT : PCM_INC;
        ctrl_d.pc_en = 1'b1;
      end
      S_JAL: begin
        ctrl_d.rwm   = RWM_LINK;
        ctrl_d.rf_en = 1'b1;
        ctrl_d.pcm   = PCM_RTGT;
        ctrl_d.pc_en = 1'b1;
      end
      S_NOP: begin
        ctrl_d.pcm   = PCM_INC;
        ctrl_d.pc_en = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are masked while reset is high so an aborted instruction never commits at the reset edge
  assign ctrl_out_c = reset ? '0 : ctrl_q;

  assign MemW1en = 1'b0;
  assign MemW2en = ctrl_out_c.mem_w2_en;
  assign RFen    = ctrl_out_c.rf_en;
  assign PSRen   = ctrl_out_c.psr_en;
  assign PCen    = ctrl_out_c.pc_en;
  assign INSTRen = ctrl_out_c.instr_en;
  assign Movm    = ctrl_out_c.movm;
  assign A1m     = ctrl_out_c.a1m;
  assign PCm     = ctrl_out_c.pcm;
  assign A2m     = ctrl_out_c.a2m;
  assign RWm     = ctrl_out_c.rwm;
  assign aluOp   = ctrl_out_c.alu_op;

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: directed vector table, reset abort, randomized model check.
module tb_control_fsm;

  typedef struct packed {
    logic       mw1;
    logic       mw2;
    logic       rf;
    logic       psr;
    logic       pc;
    logic       ie;
    logic       movm;
    logic       a1m;
    logic [1:0] pcm;
    logic [1:0] a2m;
    logic [1:0] rwm;
    logic [3:0] alu;
  } out_t;

  typedef struct {
    logic [15:0] ins;
    logic [1:0]  f1;
    logic [2:0]  f2;
    int          len;
    out_t        fin;
    string       name;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [15:0] instr;
  logic [1:0]  flags1out;
  logic [2:0]  flags2out;
  logic        MemW1en, MemW2en, RFen, PSRen, PCen, INSTRen, Movm, A1m;
  logic [1:0]  PCm, A2m, RWm;
  logic [3:0]  aluOp;

  int n_checks = 0;
  int n_pass   = 0;
  int alu_code [16];
  vec_t vecs[$];

  control_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .flags1out (flags1out),
    .flags2out (flags2out),
    .MemW1en   (MemW1en),
    .MemW2en   (MemW2en),
    .RFen      (RFen),
    .PSRen     (PSRen),
    .PCen      (PCen),
    .INSTRen   (INSTRen),
    .Movm      (Movm),
    .A1m       (A1m),
    .PCm       (PCm),
    .A2m       (A2m),
    .RWm       (RWm),
    .aluOp     (aluOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t mk(bit mw2, bit rf, bit psr, bit pc, bit movm, bit a1m,
                              bit [1:0] pcm, bit [1:0] a2m, bit [1:0] rwm, bit [3:0] alu);
    out_t o;
    o = '0;
    o.mw2 = mw2; o.rf = rf; o.psr = psr; o.pc = pc; o.movm = movm; o.a1m = a1m;
    o.pcm = pcm; o.a2m = a2m; o.rwm = rwm; o.alu = alu;
    return o;
  endfunction

  function automatic bit taken(int cnd, logic [1:0] f1, logic [2:0] f2);
    bit c, l, f, z, n;
    c = f1[1]; l = f1[0]; f = f2[2]; z = f2[1]; n = f2[0];
    case (cnd)
      0: return z;
      1: return !z;
      2: return c;
      3: return !c;
      4: return f;
      5: return !f;
      6: return n;
      7: return !n;
      10: return !l && !z;
      12: return !n && !z;
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Reference: expected last-cycle outputs and instruction length from the ISA rules
  function automatic void model(input logic [15:0] ins, input logic [1:0] f1, input logic [2:0] f2,
                                output out_t fin, output int len);
    int op, cnd, ext, code;
    op = int'(ins[15:12]); cnd = int'(ins[11:8]); ext = int'(ins[7:4]);
    fin = '0;
    fin.pc = 1'b1;
    len = 4;
    if (op == 15) begin
      fin.rf = 1'b1; fin.rwm = 2'd3;
    end else if (op == 12) begin
      fin.a1m = 1'b1; fin.a2m = 2'd2;
      fin.pcm = taken(cnd, f1, f2) ? 2'd2 : 2'd0;
    end else if (op == 4) begin
      case (ext)
        0: begin len = 5; fin.rf = 1'b1; end
        4: fin.mw2 = 1'b1;
        8: begin fin.rwm = 2'd1; fin.rf = 1'b1; fin.pcm = 2'd1; end
        12: fin.pcm = taken(cnd, f1, f2) ? 2'd1 : 2'd0;
        default: ;
      endcase
    end else begin
      code = (op == 0) ? alu_code[ext] : alu_code[op];
      if (code == 9) begin
        fin.rf = 1'b1; fin.rwm = 2'd2;
        fin.a2m = (op == 0) ? 2'd0 : 2'd2;
      end else if (code >= 0) begin
        fin.rf = (code != 2); fin.psr = 1'b1; fin.movm = 1'b1; fin.rwm = 2'd2;
        fin.alu = 4'(code);
        fin.a2m = (op == 0) ? 2'd0 : ((code >= 3) ? 2'd1 : 2'd2);
      end
    end
  endfunction

  task automatic check(input string name, input int cyc, input out_t exp);
    out_t got;
    got = {MemW1en, MemW2en, RFen, PSRen, PCen, INSTRen, Movm, A1m, PCm, A2m, RWm, aluOp};
    n_checks++;
    if (got !== exp)
      $display("FAIL %s instr=%h cycle %0d: got %b expected %b", name, instr, cyc, got, exp);
    else
      n_pass++;
  endtask

  // Called at a falling edge with the DUT in fetch; returns at the next fetch
  task automatic run_seq(input logic [15:0] ins, input logic [1:0] f1, input logic [2:0] f2,
                         input out_t fin, input int len, input string name);
    out_t exp;
    instr = ins; flags1out = f1; flags2out = f2;
    for (int c = 1; c <= len; c++) begin
      if (c > 1) @(negedge clk);
      exp = '0;
      if (c == 2) exp.ie = 1'b1;
      if (c == len) exp = fin;
      check(name, c, exp);
    end
    @(negedge clk);
  endtask

  task automatic add_vec(input logic [15:0] ins, input logic [1:0] f1, input logic [2:0] f2,
                         input int len, input out_t fin, input string name);
    vec_t v;
    v.ins = ins; v.f1 = f1; v.f2 = f2; v.len = len; v.fin = fin; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    out_t zero, fin;
    int len;
    logic [3:0] ops [13] = '{4'h0, 4'h0, 4'h4, 4'h4, 4'hC, 4'hF, 4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD};
    logic [3:0] exts [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hB, 4'hC, 4'hD, 4'h7};
    logic [15:0] ins;

    zero = '0;
    for (int i = 0; i < 16; i++) alu_code[i] = -1;
    alu_code[5] = 0; alu_code[9] = 1; alu_code[11] = 2;
    alu_code[1] = 3; alu_code[2] = 4; alu_code[3] = 5; alu_code[13] = 9;

    //        instr     f1     f2      len  mw2 rf psr pc movm a1m pcm a2m rwm alu
    add_vec(16'h0251, 2'b00, 3'b000, 4, mk(0, 1, 1, 1, 1, 0, 0, 0, 2, 0), "add");
    add_vec(16'h02B1, 2'b00, 3'b000, 4, mk(0, 0, 1, 1, 1, 0, 0, 0, 2, 2), "cmp");
    add_vec(16'h0124, 2'b00, 3'b000, 4, mk(0, 1, 1, 1, 1, 0, 0, 0, 2, 4), "or");
    add_vec(16'hF3AB, 2'b00, 3'b000, 4, mk(0, 1, 0, 1, 0, 0, 0, 0, 3, 0), "lui");
    add_vec(16'hC0FE, 2'b00, 3'b010, 4, mk(0, 0, 0, 1, 0, 1, 2, 2, 0, 0), "beq_taken");
    add_vec(16'hC0FE, 2'b11, 3'b101, 4, mk(0, 0, 0, 1, 0, 1, 0, 2, 0, 0), "beq_not");
    add_vec(16'h4304, 2'b00, 3'b000, 5, mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0), "load");
    add_vec(16'h4243, 2'b00, 3'b000, 4, mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0), "stor");
    add_vec(16'h4E8C, 2'b00, 3'b000, 4, mk(0, 1, 0, 1, 0, 0, 1, 0, 1, 0), "jal");
    add_vec(16'h41C2, 2'b00, 3'b010, 4, mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "jne_not");
    add_vec(16'h41C2, 2'b00, 3'b000, 4, mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0), "jne_taken");
    add_vec(16'h1A37, 2'b00, 3'b000, 4, mk(0, 1, 1, 1, 1, 0, 0, 1, 2, 3), "andi");
    add_vec(16'h3A37, 2'b00, 3'b000, 4, mk(0, 1, 1, 1, 1, 0, 0, 1, 2, 5), "xori");
    add_vec(16'h5A37, 2'b00, 3'b000, 4, mk(0, 1, 1, 1, 1, 0, 0, 2, 2, 0), "addi");
    add_vec(16'h9A37, 2'b00, 3'b000, 4, mk(0, 1, 1, 1, 1, 0, 0, 2, 2, 1), "subi");
    add_vec(16'hBA37, 2'b00, 3'b000, 4, mk(0, 0, 1, 1, 1, 0, 0, 2, 2, 2), "cmpi");
    add_vec(16'hD512, 2'b00, 3'b000, 4, mk(0, 1, 0, 1, 0, 0, 0, 2, 2, 0), "movi");
    add_vec(16'h02D1, 2'b00, 3'b000, 4, mk(0, 1, 0, 1, 0, 0, 0, 0, 2, 0), "mov");
    add_vec(16'h0271, 2'b00, 3'b000, 4, mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "nop_rext");
    add_vec(16'h8123, 2'b00, 3'b000, 4, mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "nop_op8");
    add_vec(16'h4120, 2'b00, 3'b000, 4, mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "nop_spec");
    add_vec(16'hCA00, 2'b10, 3'b000, 4, mk(0, 0, 0, 1, 0, 1, 2, 2, 0, 0), "blo_taken");
    add_vec(16'hCA00, 2'b00, 3'b010, 4, mk(0, 0, 0, 1, 0, 1, 0, 2, 0, 0), "blo_not");
    add_vec(16'hCF00, 2'b11, 3'b111, 4, mk(0, 0, 0, 1, 0, 1, 0, 2, 0, 0), "b_never");
    add_vec(16'hCE00, 2'b00, 3'b000, 4, mk(0, 0, 0, 1, 0, 1, 2, 2, 0, 0), "buc");

    reset = 1'b1; instr = '0; flags1out = '0; flags2out = '0;
    repeat (2) @(negedge clk);
    check("reset", 0, zero);
    reset = 1'b0;

    foreach (vecs[i])
      run_seq(vecs[i].ins, vecs[i].f1, vecs[i].f2, vecs[i].fin, vecs[i].len, vecs[i].name);

    // Reset asserted while the ALU write is being presented: enables must drop and stay low
    instr = 16'h0251; flags1out = '0; flags2out = '0;
    repeat (3) @(negedge clk);
    check("pre_reset_alu", 4, mk(0, 1, 1, 1, 1, 0, 0, 0, 2, 0));
    reset = 1'b1;
    #1;
    check("reset_mid_alu", 4, zero);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("reset_hold", k, zero);
    end
    reset = 1'b0;
    run_seq(16'h0251, 2'b00, 3'b000, mk(0, 1, 1, 1, 1, 0, 0, 0, 2, 0), 4, "after_reset");

    // Back-to-back stores: write enable is a single-cycle pulse per instruction
    run_seq(16'h4243, 2'b00, 3'b000, mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0), 4, "stor_b2b0");
    run_seq(16'h4243, 2'b00, 3'b000, mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0), 4, "stor_b2b1");

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0)
        ins = 16'($urandom);
      else
        ins = {ops[$urandom_range(0, 12)], 4'($urandom_range(0, 15)),
               exts[$urandom_range(0, 11)], 4'($urandom_range(0, 15))};
      flags1out = 2'($urandom_range(0, 3));
      flags2out = 3'($urandom_range(0, 7));
      model(ins, flags1out, flags2out, fin, len);
      run_seq(ins, flags1out, flags2out, fin, len, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
